astro_keypad_matrix: RTL and testbench
======================================

Name: astro_keypad_matrix

Overview:
- Builds the Astrocade switch matrix from PS/2 keyboard events and the four MiSTer joystick words, and drives the BALLY core's switch row inputs for the column mask it selects.
- Sits between hps_io (ps2_key, joysticks) and BALLY (O_SWITCH_COL / I_SWITCH_ROW).
- Adds a minimum-hold guarantee: a short keyboard tap is still seen by the BIOS scan.

Parameters:
- MIN_SCANS, 2: number of column selections a pressed keyboard key must be observed by before its release takes effect (1..3).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous active-high reset.
- ps2_key  in  11  [10] toggles per event, [9] 1=press/0=release, [8] extended (E0), [7:0] set-2 scan code.
- joya  in  32  hand controller 0: [0]R [1]L [2]D [3]U [4]fire, [28:5] keypad keys 0..23.
- joyb  in  32  hand controller 1, same layout.
- joyc  in  32  hand controller 2, same layout.
- joyd  in  32  hand controller 3, same layout.
- col_select  in  8  column mask from BALLY, active high; may have several bits set.
- row_data  out  8  switch rows, 1 = closed; registered.
- kbd_active  out  1  1 while any keyboard-held key bit is set.

Behaviour:
- Reset (async): key_held = 0, hold counters = 0, ps2 toggle shadow = 0, row_data = 0, kbd_active = 0, prev col_select = 0.
- PS/2 event detection:
  - Event when ps2_key[10] differs from its shadow; the shadow updates every cycle.
  - On the first cycle after reset the shadow loads ps2_key[10] with no event.
  - {ps2_key[8], ps2_key[7:0]} is looked up in the package table KEYMAP. A miss is ignored.
- Keyboard key state per key k (0..23):
  - Press event: key_held[k] = 1, hold_cnt[k] = 0, pend_rel[k] = 0.
  - Release event: if hold_cnt[k] >= MIN_SCANS, clear key_held[k] next cycle; otherwise set pend_rel[k].
- Scan counting:
  - A "scan" of column c is a rising edge of col_select[c] versus the previous cycle.
  - On a scan of key k's column (col = 4 + k/6), hold_cnt[k] increments while key_held[k] = 1, saturating at 3.
  - When pend_rel[k] = 1 and the count reaches MIN_SCANS, clear key_held[k] and pend_rel[k] in that same cycle.
- Simultaneous press event and scan for the same key: the press wins (count = 0).
- A repeat press while already held restarts the count and cancels any pending release.
- Column contents (combinational):
  - Columns 0..3 take joya..joyd: row0 = U, row1 = D, row2 = L, row3 = R, row4 = fire; rows 5..7 = 0.
  - Column 4+c, row r (c 0..3, r 0..5): key k = 6c + r is closed if key_held[k] OR joya[5+k] OR joyb[5+k] OR joyc[5+k] OR joyd[5+k]. Rows 6..7 = 0.
- row_data: registered OR across all selected columns; latency is 1 clk_sys cycle from col_select. col_select = 0 gives 0.
- kbd_active: registered |key_held.
- Joystick bits are not latched or hold-extended; they are passed through.

Decomposition:
- Package astro_input_pkg holds:
  - NUM_KEYS = 24, KP_COL_BASE = 4, KP_ROWS = 6.
  - Typedef key_idx_t (5 bits).
  - Function/constant KEYMAP: 9-bit code to {valid, key_idx}. The table entries include:
    - 0x016 '1' -> key 2, 0x01E '2' -> 8, 0x026 '3' -> 14, 0x02E '5' -> 9, 0x045 '0' -> 3.
    - 0x05A Enter -> 5 ('='), 0x079 KP+ -> 23, 0x07B KP- -> 17.
    - 0x066 Backspace -> 0 (CE), 0x076 Esc -> 6 (C).
    - The remaining keys follow the silkscreen layout.
- One sub-module, astro_key_hold: a single key's held / pend_rel / hold_cnt logic, instantiated 24 times.

Test Plan:
1. Reset asserted mid-hold with key 9 held: row_data goes to 0 asynchronously. After release, col_select = 8'h20 gives row_data = 0.
2. Press '5' (ps2_key = {~t, 1, 0, 8'h2E}), then col_select = 8'h20: one cycle later row_data = 8'h08 and kbd_active = 1.
3. Press then release '5' within 10 cycles with no scans: row_data stays 8'h08 across the first scan of 8'h20 and the second scan. After the second scan's rising edge it reads 0 on the following scan (MIN_SCANS = 2).
4. joyb = 32'h18 (U + fire), col_select = 8'h02: row_data = 8'h11. With col_select = 8'h03 and joya = 32'h1 (R), row_data = 8'h19.
5. joyc[5+23] = 1, col_select = 8'h80: row_data = 8'h20. Unknown scan code 0x0F0 press: no change, kbd_active stays 0.
6. Repeat press of Enter while pending release: key 5 stays held after 2 scans of 8'h10; it releases only after a new release event and 2 further scans.

Source files
------------

// File: rtl/astro_input_pkg.sv
// -----------------------------------------------------------------------------
// astro_input_pkg
// Shared constants, types and the PS/2 set-2 to Astrocade keypad key map used
// by the keypad matrix block and its per-key hold logic.
//   NUM_KEYS    : keypad keys per hand controller (4 columns x 6 rows)
//   KP_COL_BASE : first switch column carrying keypad keys
//   KP_ROWS     : keypad rows per column
//   KEYMAP()    : {extended, scan code} -> {valid, key index}
// -----------------------------------------------------------------------------
package astro_input_pkg;

  localparam int NUM_KEYS    = 24;
  localparam int KP_COL_BASE = 4;
  localparam int KP_ROWS     = 6;

  typedef logic [4:0] key_idx_t;

  typedef struct packed {
    logic     valid;
    key_idx_t idx;
  } keymap_t;

  // Key k sits at column KP_COL_BASE + k/6, row k%6 of the switch matrix.
  function automatic keymap_t KEYMAP(input logic [8:0] code);
    keymap_t m;
    m.valid = 1'b1;
    m.idx   = '0;
    case (code)
      9'h066: m.idx = 5'd0;   // Backspace -> CE
      9'h03D: m.idx = 5'd1;   // '7'
      9'h016: m.idx = 5'd2;   // '1'
      9'h045: m.idx = 5'd3;   // '0'
      9'h025: m.idx = 5'd4;   // '4'
      9'h05A: m.idx = 5'd5;   // Enter -> '='
      9'h076: m.idx = 5'd6;   // Esc -> C
      9'h03E: m.idx = 5'd7;   // '8'
      9'h01E: m.idx = 5'd8;   // '2'
      9'h02E: m.idx = 5'd9;   // '5'
      9'h049: m.idx = 5'd10;  // '.'
      9'h029: m.idx = 5'd11;  // Space
      9'h07C: m.idx = 5'd12;  // KP*
      9'h046: m.idx = 5'd13;  // '9'
      9'h026: m.idx = 5'd14;  // '3'
      9'h036: m.idx = 5'd15;  // '6'
      9'h14A: m.idx = 5'd16;  // KP/ (E0 4A)
      9'h07B: m.idx = 5'd17;  // KP-
      9'h005: m.idx = 5'd18;  // F1
      9'h006: m.idx = 5'd19;  // F2
      9'h004: m.idx = 5'd20;  // F3
      9'h00C: m.idx = 5'd21;  // F4
      9'h00D: m.idx = 5'd22;  // Tab
      9'h079: m.idx = 5'd23;  // KP+
      default: m.valid = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/astro_key_hold.sv
// -----------------------------------------------------------------------------
// astro_key_hold
// Held state of one keyboard-driven keypad key with a minimum-hold guarantee:
// a release only takes effect once the key's column has been scanned
// MIN_SCANS times since the last press.
//   clk_sys : system clock
//   reset   : asynchronous active-high reset
//   press   : press event for this key (one cycle)
//   rel     : release event for this key (one cycle)
//   scan    : rising edge of this key's column select
//   held    : key is closed in the matrix
// -----------------------------------------------------------------------------
module astro_key_hold
  import astro_input_pkg::*;
#(
  parameter int MIN_SCANS = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic press,
  input  logic rel,
  input  logic scan,
  output logic held
);

  localparam logic [1:0] MIN_CNT = 2'(MIN_SCANS);

  logic [1:0] hold_cnt;
  logic [1:0] cnt_next;
  logic       pend_rel;
  logic       pend_eff;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    cnt_next = hold_cnt;
    if (scan && held && hold_cnt != 2'd3)
      cnt_next = hold_cnt + 2'd1;
    pend_eff = pend_rel | (rel & held);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      held     <= 1'b0;
      hold_cnt <= '0;
      pend_rel <= 1'b0;
    end else if (press) begin
      // A press wins over a same-cycle scan and cancels any pending release.
      held     <= 1'b1;
      hold_cnt <= '0;
      pend_rel <= 1'b0;
    end else begin
      hold_cnt <= cnt_next;
      if (pend_eff && cnt_next >= MIN_CNT) begin
        held     <= 1'b0;
        pend_rel <= 1'b0;
      end else begin
        pend_rel <= pend_eff;
      end
    end
  end

endmodule

// File: rtl/astro_keypad_matrix.sv
// -----------------------------------------------------------------------------
// astro_keypad_matrix
// Builds the Astrocade switch matrix from PS/2 events and four joystick words
// and returns the OR of all selected columns to the BALLY core.
//   clk_sys    : system clock
//   reset      : asynchronous active-high reset
//   ps2_key    : [10] toggle, [9] press, [8] extended, [7:0] scan code
//   joya..joyd : [0]R [1]L [2]D [3]U [4]fire, [28:5] keypad keys 0..23
//   col_select : active-high column mask (several bits may be set)
//   row_data   : registered switch rows, 1 = closed
//   kbd_active : registered, any keyboard-held key
// -----------------------------------------------------------------------------
module astro_keypad_matrix
  import astro_input_pkg::*;
#(
  parameter int MIN_SCANS = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [31:0] joya,
  input  logic [31:0] joyb,
  input  logic [31:0] joyc,
  input  logic [31:0] joyd,
  input  logic [7:0]  col_select,
  output logic [7:0]  row_data,
  output logic        kbd_active
);

  logic                ps2_shadow;
  logic                ps2_primed;
  logic [7:0]          prev_col;
  logic                ps2_evt;
  keymap_t             map;
  logic [7:0]          scan_col;
  logic [NUM_KEYS-1:0] key_held;
  logic [7:0]          col_rows [8];
  logic [7:0]          rows_next;

  // The first cycle after reset only primes the shadow, so a toggle level
  // left over from before reset is not mistaken for an event.
  assign ps2_evt  = ps2_primed && (ps2_key[10] != ps2_shadow);
  assign map      = KEYMAP(ps2_key[8:0]);
  assign scan_col = col_select & ~prev_col;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ps2_shadow <= 1'b0;
      ps2_primed <= 1'b0;
      prev_col   <= '0;
    end else begin
      ps2_shadow <= ps2_key[10];
      ps2_primed <= 1'b1;
      prev_col   <= col_select;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    localparam int COL = KP_COL_BASE + k / KP_ROWS;
    logic hit;
    assign hit = ps2_evt && map.valid && (map.idx == key_idx_t'(k));

    astro_key_hold #(.MIN_SCANS(MIN_SCANS)) u_hold (
      .clk_sys (clk_sys),
      .reset   (reset),
      .press   (hit &  ps2_key[9]),
      .rel     (hit & ~ps2_key[9]),
      .scan    (scan_col[COL]),
      .held    (key_held[k])
    );
  end

  always_comb begin
    logic [31:0] joy [4];
    joy[0] = joya;
    joy[1] = joyb;
    joy[2] = joyc;
    joy[3] = joyd;
    for (int c = 0; c < 8; c++) col_rows[c] = '0;
    for (int c = 0; c < 4; c++) begin
      col_rows[c][0] = joy[c][3];
      col_rows[c][1] = joy[c][2];
      col_rows[c][2] = joy[c][1];
      col_rows[c][3] = joy[c][0];
      col_rows[c][4] = joy[c][4];
      for (int r = 0; r < KP_ROWS; r++) begin
        col_rows[KP_COL_BASE + c][r] = key_held[KP_ROWS * c + r]
          | joya[5 + KP_ROWS * c + r] | joyb[5 + KP_ROWS * c + r]
          | joyc[5 + KP_ROWS * c + r] | joyd[5 + KP_ROWS * c + r];
      end
    end
    rows_next = '0;
    for (int c = 0; c < 8; c++)
      if (col_select[c]) rows_next |= col_rows[c];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      row_data   <= '0;
      kbd_active <= 1'b0;
    end else begin
      row_data   <= rows_next;
      kbd_active <= |key_held;
    end
  end

endmodule

// File: tb/tb_astro_keypad_matrix.sv
module tb_astro_keypad_matrix;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [31:0] joya = '0, joyb = '0, joyc = '0, joyd = '0;
  logic [7:0]  col_select = '0;
  logic [7:0]  row_data;
  logic        kbd_active;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];
  logic [7:0] exp_rows;

  astro_keypad_matrix #(.MIN_SCANS(2)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .joya       (joya),
    .joyb       (joyb),
    .joyc       (joyc),
    .joyd       (joyd),
    .col_select (col_select),
    .row_data   (row_data),
    .kbd_active (kbd_active)
  );

  always #5 clk_sys = ~clk_sys;

  // One PS/2 event, then one idle cycle with the column mask cleared.
  task automatic ps2_event(input logic pressed, input logic [8:0] code);
    @(negedge clk_sys);
    col_select = '0;
    ps2_key = {~ps2_key[10], pressed, code};
    @(posedge clk_sys);
    #1;
  endtask

  // Drive one column mask for a cycle; the row value it must produce is
  // queued now and popped by the caller after the capturing edge.
  task automatic drive(input logic [7:0] col, input logic [7:0] expected);
    @(negedge clk_sys);
    col_select = col;
    sb.push_back(expected);
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset;
    ps2_event(1'b1, 9'h02E);
    drive(8'h20, 8'h08);
    exp_rows = sb.pop_front();
    checks++;
    if (row_data !== exp_rows) begin
      errors++;
      $display("FAIL reset_pre_hold: row_data=%h expected=%h", row_data, exp_rows);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (row_data !== 8'h00 || kbd_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: row_data=%h kbd_active=%b expected=00/0", row_data, kbd_active);
    end
    @(negedge clk_sys);
    reset = 1'b0;
    drive(8'h20, 8'h00);
    exp_rows = sb.pop_front();
    checks++;
    if (row_data !== exp_rows) begin
      errors++;
      $display("FAIL reset_cleared_key: row_data=%h expected=%h", row_data, exp_rows);
    end
    drive(8'h00, 8'h00);
    void'(sb.pop_front());
  endtask

  task automatic test_press;
    ps2_event(1'b1, 9'h02E);
    drive(8'h20, 8'h08);
    exp_rows = sb.pop_front();
    checks++;
    if (row_data !== exp_rows || kbd_active !== 1'b1) begin
      errors++;
      $display("FAIL press_5: row_data=%h kbd_active=%b expected=%h/1", row_data, kbd_active, exp_rows);
    end
    drive(8'h01, 8'h00);
    exp_rows = sb.pop_front();
    checks++;
    if (row_data !== exp_rows) begin
      errors++;
      $display("FAIL press_5_other_col: row_data=%h expected=%h", row_data, exp_rows);
    end
    ps2_event(1'b0, 9'h02E);
  endtask

  task automatic test_min_hold;
    logic [7:0] cols [5] = '{8'h20, 8'h00, 8'h20, 8'h00, 8'h20};
    logic [7:0] exps [5] = '{8'h08, 8'h00, 8'h08, 8'h00, 8'h00};
    ps2_event(1'b1, 9'h02E);
    ps2_event(1'b0, 9'h02E);
    for (int i = 0; i < 5; i++) drive(cols[i], exps[i]);
    for (int i = 0; i < 5; i++) begin
      exp_rows = sb.pop_front();
      checks++;
      if (row_data !== exp_rows && i == 4) begin
        errors++;
        $display("FAIL min_hold_final: row_data=%h expected=%h", row_data, exp_rows);
      end
    end
    // Intermediate steps are checked one at a time below with a fresh tap.
    ps2_event(1'b1, 9'h02E);
    ps2_event(1'b0, 9'h02E);
    for (int i = 0; i < 5; i++) begin
      drive(cols[i], exps[i]);
      exp_rows = sb.pop_front();
      checks++;
      if (row_data !== exp_rows) begin
        errors++;
        $display("FAIL min_hold_step%0d: row_data=%h expected=%h", i, row_data, exp_rows);
      end
    end
    drive(8'h00, 8'h00);
    void'(sb.pop_front());
    checks++;
    if (kbd_active !== 1'b0) begin
      errors++;
      $display("FAIL min_hold_kbd_active: kbd_active=%b expected=0", kbd_active);
    end
  endtask

  task automatic test_joystick;
    @(negedge clk_sys);
    joyb = 32'h18;
    drive(8'h02, 8'h11);
    exp_rows = sb.pop_front();
    checks++;
    if (row_data !== exp_rows) begin
      errors++;
      $display("FAIL joyb_up_fire: row_data=%h expected=%h", row_data, exp_rows);
    end
    @(negedge clk_sys);
    joya = 32'h1;
    drive(8'h03, 8'h19);
    exp_rows = sb.pop_front();
    checks++;
    if (row_data !== exp_rows) begin
      errors++;
      $display("FAIL joy_multi_col: row_data=%h expected=%h", row_data, exp_rows);
    end
    drive(8'h00, 8'h00);
    exp_rows = sb.pop_front();
    checks++;
    if (row_data !== exp_rows) begin
      errors++;
      $display("FAIL no_col_selected: row_data=%h expected=%h", row_data, exp_rows);
    end
    @(negedge clk_sys);
    joya = '0;
    joyb = '0;
  endtask

  task automatic test_keypad_joy_and_miss;
    @(negedge clk_sys);
    joyc = 32'h1 << 28;
    drive(8'h80, 8'h20);
    exp_rows = sb.pop_front();
    checks++;
    if (row_data !== exp_rows) begin
      errors++;
      $display("FAIL joyc_key23: row_data=%h expected=%h", row_data, exp_rows);
    end
    @(negedge clk_sys);
    joyc = '0;
    ps2_event(1'b1, 9'h0F0);
    drive(8'hF0, 8'h00);
    exp_rows = sb.pop_front();
    checks++;
    if (row_data !== exp_rows || kbd_active !== 1'b0) begin
      errors++;
      $display("FAIL unknown_code: row_data=%h kbd_active=%b expected=%h/0", row_data, kbd_active, exp_rows);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] cols [5] = '{8'h10, 8'h00, 8'h10, 8'h00, 8'h10};
    logic [7:0] held [5] = '{8'h20, 8'h00, 8'h20, 8'h00, 8'h20};
    logic [7:0] tap  [5] = '{8'h20, 8'h00, 8'h20, 8'h00, 8'h00};
    ps2_event(1'b1, 9'h05A);
    ps2_event(1'b0, 9'h05A);
    ps2_event(1'b1, 9'h05A);
    for (int i = 0; i < 5; i++) begin
      drive(cols[i], held[i]);
      exp_rows = sb.pop_front();
      checks++;
      if (row_data !== exp_rows) begin
        errors++;
        $display("FAIL repress_held_step%0d: row_data=%h expected=%h", i, row_data, exp_rows);
      end
    end
    ps2_event(1'b1, 9'h05A);
    ps2_event(1'b0, 9'h05A);
    for (int i = 0; i < 5; i++) begin
      drive(cols[i], tap[i]);
      exp_rows = sb.pop_front();
      checks++;
      if (row_data !== exp_rows) begin
        errors++;
        $display("FAIL repress_release_step%0d: row_data=%h expected=%h", i, row_data, exp_rows);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    @(posedge clk_sys);
    test_reset();
    test_press();
    test_min_hold();
    test_joystick();
    test_keypad_joy_and_miss();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
